// File: rtl/booth_mul_arbiter_if.sv
// rtl/booth_mul_arbiter_if.sv - request, multiplier and response signals of the shared booth multiplier
// slave is the arbiter side; master is the requester/multiplier side.
interface booth_mul_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;

    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_prod;
    logic                  mul_done;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;
    logic                  rsp_err;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_prod, mul_done, rsp_ready,
        output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_prod, mul_done, rsp_ready,
        input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, rsp_err, busy
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin sharing of one radix-4 booth multiplier with watchdog abort
// One operation in flight at a time: IDLE grants, ISSUE pulses start, WAIT collects, RESP returns.
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    booth_mul_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;

    // First valid requester at or after ptr, wrapping; nothing is offered while reset is held.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        if (state == IDLE && rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_any && bus.req_valid[(int'(ptr) + i) % NREQ]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'((int'(ptr) + i) % NREQ);
                end
            end
            if (gnt_any) gnt[gnt_id] = 1'b1;
        end
    end

    assign bus.req_ready = gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= '0;
            timer         <= '0;
            bus.mul_start <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_prod  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        bus.mul_a     <= bus.req_a[gnt_id*WIDTH +: WIDTH];
                        bus.mul_b     <= bus.req_b[gnt_id*WIDTH +: WIDTH];
                        bus.rsp_id    <= gnt_id;
                        bus.mul_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                // mul_done may still be high from the previous operation, so it is not looked at here.
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (bus.mul_done) begin
                        bus.rsp_prod  <= bus.mul_prod;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        bus.rsp_prod  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        ptr           <= IDW'((int'(bus.rsp_id) + 1) % NREQ);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
